// File: rtl/ia_skew_feeder.sv
// Re-times one activation row per cycle into the diagonal wavefront for the systolic array:
// lane i is delayed by i+1 cycles, with valid/calc_done carried alongside the data.
module ia_skew_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       ia_row_valid,
  input  logic                       ia_calc_done,
  input  logic                       ia_sending_done,
  input  logic [SIZE*DATA_WIDTH-1:0] ia_in,
  output logic [SIZE*DATA_WIDTH-1:0] skew_data,
  output logic [SIZE-1:0]            skew_valid,
  output logic [SIZE-1:0]            skew_calc_done,
  output logic                       skew_tile_done,
  output logic                       busy,
  output logic [15:0]                row_count
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t          state;
  logic [SIZE-1:0] inner_busy;
  logic            next_empty;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    localparam int unsigned DEPTH = i + 1;

    logic [DATA_WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0]      v;
    logic [DEPTH-1:0]      c;

    always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
        for (int unsigned j = 0; j < DEPTH; j++) d[j] <= '0;
        v <= '0;
        c <= '0;
      end else begin
        // Bubbles enter as all-zero so the array never sees stale data.
        d[0] <= ia_row_valid ? ia_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        v[0] <= ia_row_valid;
        c[0] <= ia_row_valid & ia_calc_done;
        for (int unsigned j = 1; j < DEPTH; j++) begin
          d[j] <= d[j-1];
          v[j] <= v[j-1];
          c[j] <= c[j-1];
        end
      end
    end

    assign skew_data[i*DATA_WIDTH +: DATA_WIDTH] = d[i];
    assign skew_valid[i]     = v[i];
    assign skew_calc_done[i] = c[i];

    // Valid held anywhere except the output stage: it survives the next shift.
    if (i == 0) begin : g_first
      assign inner_busy[i] = 1'b0;
    end else begin : g_rest
      assign inner_busy[i] = |v[i-1:0];
    end
  end

  // Pipeline will be empty after this edge; DONE is entered one cycle early so the
  // registered pulse lines up with the first empty cycle.
  assign next_empty = !ia_row_valid && !(|inner_busy);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state     <= IDLE;
      row_count <= '0;
    end else begin
      if (state == DONE)
        row_count <= {15'd0, ia_row_valid};
      else if (ia_row_valid && row_count != '1)
        row_count <= row_count + 16'd1;

      unique case (state)
        IDLE, DONE: begin
          if (ia_row_valid)
            state <= ia_sending_done ? DRAIN : STREAM;
          else if (ia_sending_done && next_empty)
            state <= DONE;
          else
            state <= IDLE;
        end
        STREAM: if (ia_sending_done) state <= DRAIN;
        DRAIN:  if (next_empty)      state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign skew_tile_done = (state == DONE);
  assign busy           = (state != IDLE) || (|skew_valid) || (|inner_busy);

endmodule

// File: tb/tb_ia_skew_feeder.sv
// Directed bench for ia_skew_feeder (SIZE=4): a per-lane scoreboard predicts every
// output cycle from the rows driven, plus explicit tile_done / row_count / busy points.
module tb_ia_skew_feeder;
  localparam int DW = 16;
  localparam int SZ = 4;

  logic          clk = 1'b0;
  logic          rst_n, clr, ia_row_valid, ia_calc_done, ia_sending_done;
  logic [SZ*DW-1:0] ia_in;
  logic [SZ*DW-1:0] skew_data;
  logic [SZ-1:0] skew_valid, skew_calc_done;
  logic          skew_tile_done, busy;
  logic [15:0]   row_count;

  ia_skew_feeder #(.DATA_WIDTH(DW), .SIZE(SZ)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .ia_row_valid(ia_row_valid), .ia_calc_done(ia_calc_done),
    .ia_sending_done(ia_sending_done), .ia_in(ia_in),
    .skew_data(skew_data), .skew_valid(skew_valid),
    .skew_calc_done(skew_calc_done), .skew_tile_done(skew_tile_done),
    .busy(busy), .row_count(row_count)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int lane; logic [DW-1:0] data; logic cd;} ent_t;
  ent_t q[$];
  int   tq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [SZ-1:0]    ev, ec;
    logic [SZ*DW-1:0] ed;
    logic             etd;
    int               dummy;
    ev = '0; ec = '0; ed = '0; etd = 1'b0;
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].cyc == cyc) begin
        ev[q[k].lane] = 1'b1;
        ec[q[k].lane] = q[k].cd;
        ed[q[k].lane*DW +: DW] = q[k].data;
        q.delete(k);
      end
    end
    if (tq.size() > 0 && tq[0] == cyc) begin
      etd = 1'b1;
      dummy = tq.pop_front();
    end
    chk("skew_valid", 64'(skew_valid), 64'(ev));
    chk("skew_data", 64'(skew_data), 64'(ed));
    chk("skew_calc_done", 64'(skew_calc_done), 64'(ec));
    chk("skew_tile_done", 64'(skew_tile_done), 64'(etd));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    compare_outputs();
  endtask

  // Drive one cycle of input; a valid row is expected on lane i at cyc+1+i.
  task automatic drive(input logic v, input logic cd, input logic sd, input logic [SZ*DW-1:0] row);
    ent_t e;
    ia_row_valid = v; ia_calc_done = cd; ia_sending_done = sd; ia_in = row;
    if (v) begin
      for (int i = 0; i < SZ; i++) begin
        e.cyc = cyc + 1 + i; e.lane = i; e.data = row[i*DW +: DW]; e.cd = cd;
        q.push_back(e);
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [SZ*DW-1:0] mkrow(input int s);
    logic [SZ*DW-1:0] r;
    for (int i = 0; i < SZ; i++) r[i*DW +: DW] = 16'(s * 16 + i + 1) ^ 16'h8000;
    return r;
  endfunction

  // Four back-to-back rows, sending_done with the last one.
  task automatic run_tile4(input int seed);
    int b;
    b = cyc;
    tq.push_back(b + 3 + SZ + 1);
    for (int r = 0; r < 4; r++) drive(1'b1, 1'b0, (r == 3), mkrow(seed + r));
    chk("t2_rc_after_rows", 64'(row_count), 64'd4);
    idle(3);
    chk("t2_rc_before_clear", 64'(row_count), 64'd4);
    idle(1);
    chk("t2_busy_at_done", 64'(busy), 64'd1);
    idle(1);
    chk("t2_busy_after", 64'(busy), 64'd0);
    chk("t2_rc_cleared", 64'(row_count), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    ia_row_valid = 1'b0; ia_calc_done = 1'b0; ia_sending_done = 1'b0; ia_in = '0;
    tick(); tick();
    chk("reset_row_count", 64'(row_count), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // 1) single row {1,2,3,4}, closed as a one-row tile
    tq.push_back(cyc + SZ + 1);
    drive(1'b1, 1'b0, 1'b1, {16'd4, 16'd3, 16'd2, 16'd1});
    chk("t1_rc", 64'(row_count), 64'd1);
    idle(7);

    // 2) four back-to-back rows
    run_tile4(10);
    idle(2);

    // 3) calc_done rows with a bubble whose calc_done input is high
    drive(1'b1, 1'b1, 1'b0, mkrow(30));
    drive(1'b0, 1'b1, 1'b0, mkrow(31));
    tq.push_back(cyc + SZ + 1);
    drive(1'b1, 1'b1, 1'b1, mkrow(32));
    idle(8);

    // 4) clr two cycles into a tile
    drive(1'b1, 1'b0, 1'b0, mkrow(40));
    drive(1'b1, 1'b0, 1'b0, mkrow(41));
    clr = 1'b1; ia_row_valid = 1'b1; ia_in = mkrow(42); ia_sending_done = 1'b0;
    for (int k = q.size() - 1; k >= 0; k--) if (q[k].cyc > cyc) q.delete(k);
    tick();
    clr = 1'b0;
    chk("t4_rc_after_clr", 64'(row_count), 64'd0);
    chk("t4_busy_after_clr", 64'(busy), 64'd0);
    idle(8);
    run_tile4(50);
    idle(2);

    // 5) second tile starts during DRAIN of the first
    base = cyc;
    tq.push_back(base + 7 + SZ + 1);
    for (int r = 0; r < 8; r++) drive(1'b1, 1'b0, (r == 3 || r == 7), mkrow(60 + r));
    idle(3);
    chk("t5_rc_all_rows", 64'(row_count), 64'd8);
    chk("t5_busy", 64'(busy), 64'd1);
    idle(2);
    chk("t5_rc_cleared", 64'(row_count), 64'd0);
    idle(2);

    // 6) empty tile
    tq.push_back(cyc + 1);
    drive(1'b0, 1'b0, 1'b1, '0);
    idle(3);
    chk("t6_busy", 64'(busy), 64'd0);

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    chk("tile_done_drained", 64'(tq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
